pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Sequences the video PLL (50 MHz refclk to 27 MHz pixel clock): holds PLL reset for a fixed time, waits for lock with timeout and retry, and requires lock to stay stable before releasing the system reset.
- Monitors lock in RUN and restarts the PLL on a filtered loss of lock.
- Accepts a restart request from the OSD/menu logic.
- Runs entirely in the refclk domain; downstream pixel-domain logic re-synchronises sys_rst.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per reset attempt (>=2).
- LOCK_TIMEOUT, 65536: cycles in WAIT_LOCK without lock before re-resetting the PLL.
- LOCK_STABLE_CYCLES, 1024: consecutive locked cycles required before RUN.
- LOSS_FILTER, 4: consecutive unlocked cycles in RUN that count as loss of lock.
- CNT_W, 20: width of the shared cycle counter; must hold the largest count parameter.

Ports:
- refclk  in  1  50 MHz reference clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  single-cycle request to re-run the full PLL sequence.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- pll_rst  out  1  PLL reset, active high.
- sys_rst  out  1  system reset, active high; low only in RUN.
- ready  out  1  high only in RUN.
- lock_lost  out  1  one-cycle pulse on a filtered loss of lock in RUN.
- retry_count  out  8  number of LOCK_TIMEOUT expiries; saturates at 255.

Behaviour:
- Lock synchroniser: pll_locked passes through 2 flops to give locked_s, adding 2 cycles of latency. Both flops clear on rst.
- Reset: state=RESET_PLL, counter=0, pll_rst=1, sys_rst=1, ready=0, lock_lost=0, retry_count=0. Reset wins over everything else.
- Output timing: all outputs are registered and decoded from the next state, so they change on the same edge as the state register.
- Single counter: cleared on every state transition.
- RESET_PLL:
  - pll_rst=1; counter increments.
  - When counter==RST_CYCLES-1, go to WAIT_LOCK. The state therefore lasts exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABILIZE.
  - Otherwise the counter increments. When counter==LOCK_TIMEOUT-1, go to RESET_PLL and increment retry_count (saturating).
- STABILIZE:
  - If locked_s=0, return to WAIT_LOCK; retry_count is unchanged.
  - Otherwise the counter increments. When counter==LOCK_STABLE_CYCLES-1, go to RUN.
- RUN:
  - sys_rst=0, ready=1.
  - The counter counts consecutive locked_s=0 cycles and clears whenever locked_s=1.
  - When it reaches LOSS_FILTER, go to RESET_PLL and pulse lock_lost=1 for exactly one cycle.
  - Shorter dropouts are ignored.
- restart=1 in any state:
  - Next state is RESET_PLL with the counter cleared.
  - Takes priority over every other transition, including one that completes in the same cycle.
  - Does not increment retry_count. Does not pulse lock_lost.
  - restart while already in RESET_PLL restarts the count.
- sys_rst and ready:
  - Asserted in every non-RUN state.
  - sys_rst=1 on the same edge RUN is left; it never glitches low outside RUN.
- No other state encodings are reachable. An illegal state recovers to RESET_PLL on the next edge.

Test Plan:
Test parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, LOSS_FILTER=3. Cycle 0 is the first cycle with rst=0.
1. Power-up with pll_locked held at 1 -> pll_rst=1 in cycles 0-3; WAIT_LOCK lasts 1 cycle; STABILIZE lasts 8 cycles; sys_rst=0 and ready=1 from cycle 13; retry_count=0.
2. pll_locked stuck at 0 -> pll_rst is re-asserted every 36 cycles (4+32); retry_count increments each time and saturates at 255 after 255 timeouts; sys_rst stays 1 throughout.
3. In RUN, pll_locked drops for 2 cycles -> no response: ready stays 1 and lock_lost stays 0. Dropout of 3 cycles -> one lock_lost pulse, pll_rst=1 for 4 cycles, and sys_rst=1 on the same edge.
4. In STABILIZE, pll_locked drops 1 cycle at count 5 -> return to WAIT_LOCK and the stable count restarts. RUN is reached 8 full stable cycles after relock; retry_count is unchanged.
5. restart pulsed in RUN, and again on the exact cycle STABILIZE would enter RUN -> RESET_PLL in both cases (restart wins); lock_lost=0; retry_count unchanged.
6. rst asserted mid-WAIT_LOCK with retry_count=3 -> the next edge gives all reset values (retry_count=0, pll_rst=1); the sequence then repeats scenario 1 timing exactly.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer for the video PLL (50 MHz refclk -> 27 MHz pixel clock).
// Holds the PLL in reset, waits for lock with timeout/retry, requires lock to
// stay stable before releasing the system reset, and watches for loss of lock
// while running. Everything lives in the refclk domain.
module pll_lock_sequencer #(
    parameter int RST_CYCLES         = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOSS_FILTER        = 4,
    parameter int CNT_W              = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       restart,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retry_count
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Terminal counts for each timed state.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             sync_ff;
    logic             locked_s;
    logic             timeout;
    logic             loss;

    // Two-flop synchroniser for the asynchronous PLL lock indicator.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_ff  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_ff  <= pll_locked;
            locked_s <= sync_ff;
        end
    end

    // Next-state, shared counter and event decode; restart overrides everything.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_nxt = state;
        count_nxt = count + CNT_W'(1);
        timeout   = 1'b0;
        loss      = 1'b0;

        case (state)
            RESET_PLL: begin
                if (count == RST_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = STABILIZE;
                end else if (count == TIMEOUT_LAST) begin
                    state_nxt = RESET_PLL;
                    timeout   = 1'b1;
                end
            end
            STABILIZE: begin
                if (!locked_s)                  state_nxt = WAIT_LOCK;
                else if (count == STABLE_LAST)  state_nxt = RUN;
            end
            RUN: begin
                // Counter tracks the length of the current dropout only.
                if (locked_s) begin
                    count_nxt = '0;
                end else if (count == LOSS_LAST) begin
                    state_nxt = RESET_PLL;
                    loss      = 1'b1;
                end
            end
            default: state_nxt = RESET_PLL;
        endcase

        if (restart) begin
            state_nxt = RESET_PLL;
            timeout   = 1'b0;
            loss      = 1'b0;
        end

        // Any transition, or a restart within RESET_PLL, starts the count afresh.
        if (state_nxt != state || restart) count_nxt = '0;
    end

    // State, counter and outputs registered from the next state so they move together.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= RESET_PLL;
            count       <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state     <= state_nxt;
            count     <= count_nxt;
            pll_rst   <= (state_nxt == RESET_PLL);
            sys_rst   <= (state_nxt != RUN);
            ready     <= (state_nxt == RUN);
            lock_lost <= loss;
            if (timeout && retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: a phase/duration model checked on
// every cycle, plus hand-computed cycle-exact expectations for each scenario.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES         = 4;
    localparam int LOCK_TIMEOUT       = 32;
    localparam int LOCK_STABLE_CYCLES = 8;
    localparam int LOSS_FILTER        = 3;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       restart = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_count;

    int n_pass  = 0;
    int n_total = 0;
    int cur     = 0;

    pll_lock_sequencer #(
        .RST_CYCLES        (RST_CYCLES),
        .LOCK_TIMEOUT      (LOCK_TIMEOUT),
        .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
        .LOSS_FILTER       (LOSS_FILTER),
        .CNT_W             (20)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .restart    (restart),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    always #10 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Phases with entry times; durations are judged by elapsed cycles.
    localparam int PH_RESET = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3;
    int ph         = PH_RESET;
    int entered    = 0;
    int mcyc       = 0;
    int unlocked   = 0;
    int retries    = 0;
    bit pulse      = 1'b0;
    bit seen_rst   = 1'b0;
    bit lk_d1      = 1'b0;
    bit lk_d2      = 1'b0;

    always @(posedge refclk) begin
        bit ls;
        int spent;
        ls    = lk_d2;
        spent = mcyc - entered + 1;
        pulse = 1'b0;
        if (rst) begin
            ph = PH_RESET; entered = mcyc + 1; retries = 0;
            lk_d1 = 1'b0; lk_d2 = 1'b0; seen_rst = 1'b1;
        end else begin
            lk_d2 = lk_d1;
            lk_d1 = pll_locked;
            if (restart) begin
                ph = PH_RESET; entered = mcyc + 1;
            end else if (ph == PH_RESET) begin
                if (spent == RST_CYCLES) begin ph = PH_WAIT; entered = mcyc + 1; end
            end else if (ph == PH_WAIT) begin
                if (ls) begin
                    ph = PH_STAB; entered = mcyc + 1;
                end else if (spent == LOCK_TIMEOUT) begin
                    ph = PH_RESET; entered = mcyc + 1;
                    retries = (retries < 255) ? retries + 1 : 255;
                end
            end else if (ph == PH_STAB) begin
                if (!ls) begin
                    ph = PH_WAIT; entered = mcyc + 1;
                end else if (spent == LOCK_STABLE_CYCLES) begin
                    ph = PH_RUN; entered = mcyc + 1; unlocked = 0;
                end
            end else begin
                unlocked = ls ? 0 : unlocked + 1;
                if (unlocked == LOSS_FILTER) begin
                    ph = PH_RESET; entered = mcyc + 1; pulse = 1'b1;
                end
            end
        end
        mcyc++;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge refclk) begin
        if (seen_rst) begin
            check("model_pll_rst",   {31'd0, pll_rst},   {31'd0, ph == PH_RESET});
            check("model_sys_rst",   {31'd0, sys_rst},   {31'd0, ph != PH_RUN});
            check("model_ready",     {31'd0, ready},     {31'd0, ph == PH_RUN});
            check("model_lock_lost", {31'd0, lock_lost}, {31'd0, pulse});
            check("model_retry",     {24'd0, retry_count}, retries);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge refclk);
        #1;
        cur++;
    endtask

    task automatic run_to(input int c);
        while (cur < c) step();
    endtask

    task automatic do_reset(input bit lk);
        rst = 1'b1; restart = 1'b0; pll_locked = lk;
        repeat (3) step();
        rst = 1'b0;
        cur = 0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    // Power-up with lock present: RESET 0-3, WAIT 4, STABILIZE 5-12, RUN from 13.
    task automatic power_up_checks(input string tag);
        for (int c = 0; c <= 3; c++) begin
            run_to(c);
            check({tag, "_pll_rst_hold"}, {31'd0, pll_rst}, 32'd1);
        end
        run_to(4);
        check({tag, "_pll_rst_rel"},  {31'd0, pll_rst}, 32'd0);
        check({tag, "_wait_sysrst"},  {31'd0, sys_rst}, 32'd1);
        run_to(12);
        check({tag, "_c12_ready"},    {31'd0, ready},   32'd0);
        run_to(13);
        check({tag, "_c13_ready"},    {31'd0, ready},   32'd1);
        check({tag, "_c13_sysrst"},   {31'd0, sys_rst}, 32'd0);
        check({tag, "_retry"},        {24'd0, retry_count}, 32'd0);
    endtask

    initial begin
        int lost_n;
        int rdy_low;
        int sys_low;

        // Scenario 1: clean power-up.
        do_reset(1'b1);
        check("reset_pll_rst",  {31'd0, pll_rst},   32'd1);
        check("reset_sys_rst",  {31'd0, sys_rst},   32'd1);
        check("reset_ready",    {31'd0, ready},     32'd0);
        check("reset_lost",     {31'd0, lock_lost}, 32'd0);
        check("reset_retry",    {24'd0, retry_count}, 32'd0);
        power_up_checks("pwr");

        // Scenario 3a: 2-cycle dropout in RUN is filtered.
        run_to(20);
        pll_locked = 1'b0;
        run_to(22);
        pll_locked = 1'b1;
        lost_n = 0; rdy_low = 0;
        while (cur < 32) begin
            if (lock_lost) lost_n++;
            if (!ready)    rdy_low++;
            step();
        end
        check("short_drop_lost",  lost_n,  32'd0);
        check("short_drop_ready", rdy_low, 32'd0);

        // Scenario 3b: 3-cycle dropout -> loss at cycle 45.
        run_to(40);
        pll_locked = 1'b0;
        run_to(43);
        pll_locked = 1'b1;
        run_to(44);
        check("loss_c44_ready",  {31'd0, ready},     32'd1);
        check("loss_c44_lost",   {31'd0, lock_lost}, 32'd0);
        run_to(45);
        check("loss_c45_lost",   {31'd0, lock_lost}, 32'd1);
        check("loss_c45_pllrst", {31'd0, pll_rst},   32'd1);
        check("loss_c45_sysrst", {31'd0, sys_rst},   32'd1);
        check("loss_c45_ready",  {31'd0, ready},     32'd0);
        run_to(46);
        check("loss_c46_lost",   {31'd0, lock_lost}, 32'd0);
        run_to(48);
        check("loss_c48_pllrst", {31'd0, pll_rst},   32'd1);
        run_to(49);
        check("loss_c49_pllrst", {31'd0, pll_rst},   32'd0);
        run_to(58);
        check("relock_c58_ready", {31'd0, ready},    32'd1);

        // Scenario 5: restart in RUN, on the STABILIZE->RUN edge, and inside RESET_PLL.
        run_to(65);
        pulse_restart();
        check("rs_run_pllrst", {31'd0, pll_rst},   32'd1);
        check("rs_run_ready",  {31'd0, ready},     32'd0);
        check("rs_run_lost",   {31'd0, lock_lost}, 32'd0);
        run_to(78);
        check("rs_stab_c78_ready", {31'd0, ready}, 32'd0);
        pulse_restart();
        check("rs_stab_pllrst", {31'd0, pll_rst},  32'd1);
        check("rs_stab_ready",  {31'd0, ready},    32'd0);
        run_to(80);
        pulse_restart();
        run_to(84);
        check("rs_rst_c84_pllrst", {31'd0, pll_rst}, 32'd1);
        run_to(85);
        check("rs_rst_c85_pllrst", {31'd0, pll_rst}, 32'd0);
        run_to(93);
        check("rs_c93_ready", {31'd0, ready}, 32'd0);
        run_to(94);
        check("rs_c94_ready", {31'd0, ready}, 32'd1);
        check("rs_retry",     {24'd0, retry_count}, 32'd0);
        run_to(100);

        // Scenario 4: one-cycle dropout at stable count 5.
        do_reset(1'b1);
        run_to(8);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        run_to(11);
        check("stab_drop_c11_ready",  {31'd0, ready},   32'd0);
        check("stab_drop_c11_pllrst", {31'd0, pll_rst}, 32'd0);
        run_to(19);
        check("stab_drop_c19_ready",  {31'd0, ready},   32'd0);
        run_to(20);
        check("stab_drop_c20_ready",  {31'd0, ready},   32'd1);
        check("stab_drop_retry",      {24'd0, retry_count}, 32'd0);

        // Scenario 6: rst mid-WAIT_LOCK with three retries recorded.
        do_reset(1'b0);
        run_to(35);
        check("to_c35_pllrst", {31'd0, pll_rst},     32'd0);
        check("to_c35_retry",  {24'd0, retry_count}, 32'd0);
        run_to(36);
        check("to_c36_pllrst", {31'd0, pll_rst},     32'd1);
        check("to_c36_retry",  {24'd0, retry_count}, 32'd1);
        run_to(120);
        check("mid_wait_retry", {24'd0, retry_count}, 32'd3);
        check("mid_wait_pllrst", {31'd0, pll_rst},    32'd0);
        rst = 1'b1;
        step();
        check("rerst_retry",  {24'd0, retry_count}, 32'd0);
        check("rerst_pllrst", {31'd0, pll_rst},     32'd1);
        check("rerst_ready",  {31'd0, ready},       32'd0);
        rst = 1'b0;
        pll_locked = 1'b1;
        cur = 0;
        power_up_checks("rerst");
        run_to(20);

        // Scenario 2: lock never arrives; retries saturate at 255.
        do_reset(1'b0);
        sys_low = 0;
        while (cur < 256 * 36 + 4) begin
            if (!sys_rst) sys_low++;
            if (cur == 255 * 36 - 1)
                check("sat_c9179_retry", {24'd0, retry_count}, 32'd254);
            if (cur == 255 * 36)
                check("sat_c9180_retry", {24'd0, retry_count}, 32'd255);
            if (cur == 256 * 36)
                check("sat_c9216_pllrst", {31'd0, pll_rst}, 32'd1);
            step();
        end
        check("sat_final_retry", {24'd0, retry_count}, 32'd255);
        check("sat_sysrst_low",  sys_low, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
